// File: rtl/inst_fetch.sv
// Purpose: instruction-fetch front end; owns the PC, fetches words over req/ack, detects exit syscall, counts retirements.
// Latency: advance at edge k -> imem_req in cycle k+1 -> IM/inst_valid from edge k+2 with zero-wait memory (+1 per wait cycle).
// Backpressure: the current instruction is held until advance; memory wait states stall in REQ indefinitely.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] NextPC,
    input  logic [31:0] RegRS,
    input  logic        advance,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] PC,
    output logic [31:0] IM,
    output logic        inst_valid,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc_nxt;
    logic [31:0] im_nxt;
    logic [31:0] retired_nxt;
    logic        halted_nxt;
    logic        fault_nxt;

    logic        pc_aligned;
    logic        exit_syscall;

    // A word fetch is only legal on a 4-byte boundary.
    assign pc_aligned   = (PC[1:0] == 2'b00);

    // Exit service: R-type syscall with service code 10 in $v0 (delivered on RegRS).
    assign exit_syscall = (IM[31:26] == 6'h00) && (IM[5:0] == 6'h0c) &&
                          (RegRS == 32'h0000000a);

    // State register; reset returns to IDLE from any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and architectural register updates.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = PC;
        im_nxt      = IM;
        retired_nxt = retired;
        halted_nxt  = halted;
        fault_nxt   = fault;
        case (state)
            IDLE: begin
                state_nxt = REQ;
            end
            REQ: begin
                if (!pc_aligned) begin
                    // Never touch memory with a misaligned address; stop for good.
                    fault_nxt  = 1'b1;
                    halted_nxt = 1'b1;
                    state_nxt  = HALT;
                end else if (imem_ack) begin
                    im_nxt    = imem_rdata;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (advance) begin
                    retired_nxt = retired + 32'd1;
                    if (exit_syscall) begin
                        // PC stays on the syscall so it remains observable after halting.
                        halted_nxt = 1'b1;
                        state_nxt  = HALT;
                    end else begin
                        pc_nxt    = NextPC;
                        state_nxt = REQ;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // PC, instruction word, status flags and retirement counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC      <= RESET_PC;
            IM      <= 32'h00000000;
            retired <= 32'h00000000;
            halted  <= 1'b0;
            fault   <= 1'b0;
        end else begin
            PC      <= pc_nxt;
            IM      <= im_nxt;
            retired <= retired_nxt;
            halted  <= halted_nxt;
            fault   <= fault_nxt;
        end
    end

    // Handshake outputs decode from state and PC only, so reset drops the request at once.
    assign imem_req   = (state == REQ) && pc_aligned;
    assign imem_addr  = PC;
    assign inst_valid = (state == HOLD);

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] NextPC = 32'h0;
    logic [31:0] RegRS = 32'h0;
    logic        advance = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] PC;
    logic [31:0] IM;
    logic        inst_valid;
    logic        halted;
    logic        fault;
    logic [31:0] retired;

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .NextPC(NextPC), .RegRS(RegRS), .advance(advance),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_req(imem_req),
        .imem_addr(imem_addr), .PC(PC), .IM(IM), .inst_valid(inst_valid),
        .halted(halted), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic [31:0] ret;
        int          lat;
    } val_t;

    typedef struct {
        logic        flt;
        logic [31:0] ret;
    } halt_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] q_req [$];
    val_t        q_val [$];
    halt_t       q_halt [$];
    logic [31:0] exp_ret;
    logic [31:0] cur_word;
    int          cur_waits;
    bit          abort;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    function automatic logic [31:0] gen_word(input int run, input int j, input int n);
        logic [31:0] w;
        w = $urandom;
        if (run == 0 && j == 0) return 32'h08084210;
        if (run == 0 && j == 1) return 32'h0000000c;
        if (j == n - 1 && run != 1) return 32'h0000000c;
        case ($urandom_range(0, 4))
            0: w = {6'h02, w[25:0]};
            1: w = {6'h00, w[25:6], 6'h0c};
            default: if (w[31:26] == 6'h00 && w[5:0] == 6'h0c) w[0] = ~w[0];
        endcase
        return w;
    endfunction

    function automatic int waits_for(input int run, input int j);
        if (run == 0) return (j < 2) ? 0 : ((j == 2) ? 5 : $urandom_range(0, 3));
        if (run == 2 && j == 2) return 3;
        return $urandom_range(0, 4);
    endfunction

    // Plan the fetch at addr: choose its word and memory delay, record what the DUT must show.
    task automatic plan_fetch(input int run, input int j, input int n, input logic [31:0] addr,
                              input bit first);
        val_t v;
        cur_word  = gen_word(run, j, n);
        cur_waits = waits_for(run, j);
        mem[addr] = cur_word;
        q_req.push_back(addr);
        v.addr = addr;
        v.word = cur_word;
        v.ret  = exp_ret;
        v.lat  = first ? -1 : 2 + cur_waits;
        q_val.push_back(v);
    endtask

    task automatic do_reset(input int run, input int n);
        rst = 1'b1;
        advance = 1'b0;
        imem_ack = 1'b0;
        q_req.delete();
        q_val.delete();
        q_halt.delete();
        mem.delete();
        @(negedge clk);
        @(negedge clk);
        check("rst_pc", PC, RESET_PC);
        check("rst_im", IM, 32'h0);
        check("rst_retired", retired, 32'h0);
        check("rst_flags", {27'd0, imem_req, inst_valid, halted, fault, 1'b0}, 32'h0);
        exp_ret = 32'h0;
        plan_fetch(run, 0, n, RESET_PC, 1'b1);
        rst = 1'b0;
    endtask

    // Memory side: wait for a request, stall the planned cycles, then return the word.
    task automatic serve(input int waits, input bit mid_reset, output bit ok);
        int n;
        ok = 1'b1;
        n = 0;
        while (imem_req !== 1'b1) begin
            if (n == 40) begin
                check("req_timeout", {31'd0, imem_req}, 32'd1);
                ok = 1'b0;
                return;
            end
            @(negedge clk);
            n++;
            imem_ack = 1'b0;
        end
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            advance  = 1'($urandom_range(0, 1));
            NextPC   = $urandom;
            @(negedge clk);
        end
        advance    = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = mem.exists(imem_addr) ? mem[imem_addr] : 32'hdeadbeef;
        if (mid_reset) begin
            rst = 1'b1;
            q_req.delete();
            q_val.delete();
            q_halt.delete();
            #1;
            check("midrst_req", {31'd0, imem_req}, 32'd0);
            check("midrst_valid", {31'd0, inst_valid}, 32'd0);
            check("midrst_pc", PC, RESET_PC);
            check("midrst_retired", retired, 32'h0);
            @(posedge clk);
            #1;
            check("midrst_im_after_ack", IM, 32'h0);
            @(negedge clk);
            imem_ack = 1'b0;
            return;
        end
        @(negedge clk);
        imem_ack = 1'b0;
        n = 0;
        while (inst_valid !== 1'b1) begin
            if (n == 40) begin
                check("valid_timeout", {31'd0, inst_valid}, 32'd1);
                ok = 1'b0;
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic retire(input logic [31:0] npc, input logic [31:0] rs);
        NextPC  = npc;
        RegRS   = rs;
        advance = 1'b1;
        @(negedge clk);
        advance  = 1'b0;
        imem_ack = 1'b0;
        NextPC   = $urandom;
        RegRS    = $urandom;
    endtask

    // Stimulus: core and memory behaviour, with expectations pushed as decisions are made.
    initial begin : driver
        int          n_inst;
        bit          ok;
        bit          mid;
        bit          halt_run;
        logic [31:0] npc;
        logic [31:0] rs;
        abort = 1'b0;
        for (int run = 0; run < 8 && !abort; run++) begin
            n_inst = (run == 0) ? 6 : $urandom_range(4, 12);
            do_reset(run, n_inst);
            for (int i = 0; i < n_inst; i++) begin
                mid = (run == 2 && i == 2);
                serve(cur_waits, mid, ok);
                if (!ok) begin
                    abort = 1'b1;
                    break;
                end
                if (mid) break;
                repeat ($urandom_range(0, 3)) begin
                    imem_ack   = 1'($urandom_range(0, 1));
                    imem_rdata = $urandom;
                    @(negedge clk);
                end
                rs  = $urandom;
                if ($urandom_range(0, 3) == 0) rs = 32'h0000000a;
                npc = $urandom & 32'hfffffffc;
                if (run == 0 && i == 0) npc = 32'h00210840;
                if (run == 0 && i == 1) rs = 32'h00000004;
                if (i == n_inst - 1) begin
                    if (run == 1) begin
                        npc = 32'h00000006;
                        rs  = 32'h0;
                    end else if (run >= 3 && $urandom_range(0, 1) == 1) begin
                        npc = ($urandom & 32'hfffffffc) | 32'($urandom_range(1, 3));
                        rs  = 32'h0;
                    end else begin
                        rs  = 32'h0000000a;
                    end
                end
                exp_ret  = exp_ret + 32'd1;
                halt_run = 1'b1;
                if (cur_word[31:26] == 6'h00 && cur_word[5:0] == 6'h0c && rs == 32'h0000000a)
                    q_halt.push_back('{flt: 1'b0, ret: exp_ret});
                else if (npc[1:0] != 2'b00)
                    q_halt.push_back('{flt: 1'b1, ret: exp_ret});
                else begin
                    halt_run = 1'b0;
                    plan_fetch(run, i + 1, n_inst, npc, 1'b0);
                end
                retire(npc, rs);
                if (halt_run) begin
                    repeat (6) begin
                        imem_ack   = 1'($urandom_range(0, 1));
                        imem_rdata = $urandom;
                        @(negedge clk);
                    end
                    imem_ack = 1'b0;
                    break;
                end
            end
        end
        repeat (2) @(negedge clk);
        check("drain_req", 32'(q_req.size()), 32'd0);
        check("drain_val", 32'(q_val.size()), 32'd0);
        check("drain_halt", 32'(q_halt.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Monitor: compares DUT-presented events against the scoreboard queues.
    initial begin : monitor
        bit          prev_req;
        bit          prev_val;
        bit          prev_halt;
        bit          prev_ack_edge;
        bit          im_ok;
        logic [31:0] cur_addr;
        logic [31:0] prev_im;
        int          cnt;
        val_t        v;
        halt_t       h;
        prev_req = 0; prev_val = 0; prev_halt = 0; prev_ack_edge = 0; im_ok = 0;
        cur_addr = 32'h0; prev_im = 32'h0; cnt = -1;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_req = 0; prev_val = 0; prev_halt = 0; prev_ack_edge = 0;
                im_ok = 0; cnt = -1;
            end else begin
                if (cnt >= 0) cnt++;
                if (imem_req && !prev_req) begin
                    check("req_expected", {31'd0, q_req.size() != 0}, 32'd1);
                    cur_addr = (q_req.size() != 0) ? q_req.pop_front() : 32'hffffffff;
                end
                if (imem_req) check("req_addr", imem_addr, cur_addr);
                if (inst_valid && !prev_val) begin
                    check("valid_expected", {31'd0, q_val.size() != 0}, 32'd1);
                    if (q_val.size() != 0) begin
                        v = q_val.pop_front();
                        check("im_word", IM, v.word);
                        check("pc_value", PC, v.addr);
                        check("retired_count", retired, v.ret);
                        if (v.lat >= 0) check("fetch_latency", 32'(cnt), 32'(v.lat));
                    end
                end
                if (im_ok && !prev_ack_edge) check("im_stable", IM, prev_im);
                if (halted && !prev_halt) begin
                    check("halt_expected", {31'd0, q_halt.size() != 0}, 32'd1);
                    if (q_halt.size() != 0) begin
                        h = q_halt.pop_front();
                        check("halt_fault", {31'd0, fault}, {31'd0, h.flt});
                        check("halt_retired", retired, h.ret);
                        check("halt_valid", {31'd0, inst_valid}, 32'd0);
                    end
                end
                if (halted) check("req_when_halted", {31'd0, imem_req}, 32'd0);
                if (inst_valid && advance) cnt = 0;
                prev_ack_edge = imem_req && imem_ack;
                prev_im  = IM;
                im_ok    = 1;
                prev_req = imem_req;
                prev_val = inst_valid;
                prev_halt = halted;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: run still active at 1ms, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch front end for the single-cycle MIPS datapath: owns the architectural PC register, requests instruction words from instruction memory over a req/ack handshake, and presents `PC`/`IM` to the next-PC logic. The next-PC logic returns `NextPC`, and the fetch unit loads it when the core advances. The unit also detects the exit syscall (`syscall` with `$v0`, presented on `RegRS`, equal to 10) and halts. It counts retired instructions.

## Interface
- `RESET_PC`, 32'h00000000, PC value loaded by reset
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `NextPC`  in  32  next PC from next-PC logic; valid while `inst_valid`=1
- `RegRS`  in  32  rs register read value, used for syscall service code
- `advance`  in  1  core accepts the current instruction; ignored unless `inst_valid`=1
- `imem_ack`  in  1  memory returns data this cycle; sampled only in REQ
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  byte address of fetch (equals `PC`)
- `PC`  out  32  address of the current instruction
- `IM`  out  32  current instruction word (registered)
- `inst_valid`  out  1  `IM` holds a fetched, not yet retired instruction
- `halted`  out  1  exit syscall retired; sticky until reset
- `fault`  out  1  misaligned PC detected; sticky until reset
- `retired`  out  32  instructions retired since reset

## Operation
- States: IDLE, REQ, HOLD, HALT.
- Reset (async, any state): state=IDLE, `PC`=`RESET_PC`, `IM`=0, `retired`=0. All 1-bit outputs are 0.
- IDLE: transitions to REQ on the next clock. No outputs are asserted.
- REQ, when `PC[1:0]`≠0:
  - Drive nothing.
  - Set `fault`=1 and `halted`=1 at the next edge, and go to HALT.
  - No memory request is ever issued for a misaligned address.
- REQ, when aligned:
  - `imem_req`=1 and `imem_addr`=`PC`. Both are held stable until ack.
  - On an edge with `imem_ack`=1: `IM`←`imem_rdata`, then go to HOLD.
  - Wait states (`imem_ack`=0) are unbounded.
- HOLD: `inst_valid`=1 and `imem_req`=0. `IM` and `PC` are stable.
  - `advance`=0: stay in HOLD.
  - `advance`=1 with exit syscall (`IM[31:26]`=0, `IM[5:0]`=6'h0c, `RegRS`=32'h0000000a):
    - `retired`+1, `halted`←1, go to HALT.
    - `PC` is not updated.
  - `advance`=1 otherwise: `PC`←`NextPC`, `retired`+1, go to REQ.
  - A syscall with any other `RegRS` value retires as a normal instruction.
- HALT: all requests stop and `inst_valid`=0. The state holds until `rst`.
- `imem_ack` outside REQ is ignored; `IM` is not modified.
- `retired` wraps from 32'hffffffff to 0.

## Timing
- Outputs are registered, except `imem_req`, `imem_addr` and `inst_valid`, which are decoded from state and `PC` only. There is no combinational path from any input to any output.
- First request: `imem_req` rises in the first cycle after the reset-release edge plus one edge (IDLE→REQ).
- Fetch latency with zero-wait memory: `advance` sampled at edge k gives `imem_req`=1 in cycle k+1, an ack in the same cycle, and `inst_valid`=1 from edge k+2. Each added wait cycle adds one cycle.
- `retired` increments at the same edge that samples `advance`=1 in HOLD.
- Reset asserted mid-REQ:
  - `imem_req` drops immediately (asynchronously).
  - An ack arriving in the same cycle is discarded.

## Test plan
- Reset/first fetch:
  - Release `rst` with ack tied high → `imem_req`=1 with `imem_addr`=0x00000000 two edges after release.
  - `IM`=`imem_rdata` and `inst_valid`=1 on the following cycle.
- Jump flow:
  - `IM`=0x08084210, `NextPC`=0x00210840, pulse `advance` → `retired`=1.
  - Next request has `imem_addr`=0x00210840, with `inst_valid` low for exactly 1 cycle.
- Wait states:
  - Hold `imem_ack`=0 for 5 cycles in REQ → `imem_req` and `imem_addr` stay constant.
  - `IM` is loaded only at the ack edge.
- Exit syscall:
  - `IM`=0x0000000c, `RegRS`=0x0000000a, `advance`=1 → `halted`=1, `inst_valid`=0, no further `imem_req`, `retired` incremented once.
  - Same instruction with `RegRS`=0x00000004 → normal retire, with PC←`NextPC`.
- Misaligned target:
  - `NextPC`=0x00000006 on advance → `fault`=1 and `halted`=1.
  - `imem_req` never asserted for 0x00000006.
- Reset mid-operation:
  - Assert `rst` during REQ with a concurrent ack → outputs return to reset values immediately, `IM` stays 0, and fetch restarts at `RESET_PC`.
